// File: rtl/instr_fetch.sv
// Fetch stage: drives the PC to instruction memory, buffers fetched words with
// their PC in a small prefetch FIFO and hands them to decode over valid/ready.
module instr_fetch #(
   parameter int unsigned        ADDR_W    = 16,
   parameter int unsigned        DATA_W    = 32,
   parameter int unsigned        DEPTH     = 2,
   parameter int unsigned        MEM_WORDS = 256,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              imem_busy,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic              halt,
   output logic              fault
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W:0]   MEM_LIM = (ADDR_W+1)'(MEM_WORDS);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [ADDR_W-1:0] fifo_pc   [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q;

   logic head_valid;
   logic pop;
   logic room;
   logic pc_in_range;
   logic is_halt_word;
   logic fetch_en;
   logic push;

   // Datapath control: range check is one bit wider so MEM_WORDS == 2^ADDR_W works.
   always_comb begin
      head_valid   = (count_q != '0);
      pop          = head_valid && inst_ready;
      room         = (count_q < DEPTH_C) || pop;
      pc_in_range  = ({1'b0, pc_q} < MEM_LIM);
      is_halt_word = (imem_data == HALT_WORD);
      fetch_en     = (state_q == ST_RUN) && !redirect_valid && !imem_busy &&
                     pc_in_range && room;
      push         = fetch_en && !is_halt_word;
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = ST_RUN;
      end else if ((state_q == ST_RUN) && !imem_busy) begin
         if (!pc_in_range) begin
            state_d = ST_FAULT;
         end else if (room && is_halt_word) begin
            state_d = ST_HALT;
         end
      end
   end

   // FSM: outputs
   always_comb begin
      halt  = (state_q == ST_HALT);
      fault = (state_q == ST_FAULT);
   end

   // PC and FIFO bookkeeping; a redirect flushes but a same-cycle pop was still delivered.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (redirect_valid) begin
         pc_q     <= redirect_pc;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            pc_q     <= pc_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset && !redirect_valid) begin
         fifo_data[wr_ptr_q] <= imem_data;
         fifo_pc[wr_ptr_q]   <= pc_q;
      end
   end

   always_comb begin
      imem_addr  = pc_q;
      inst_valid = head_valid;
      inst       = head_valid ? fifo_data[rd_ptr_q] : '0;
      inst_pc    = head_valid ? fifo_pc[rd_ptr_q]   : '0;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_instr_fetch;

   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned DEP = 2;
   localparam int unsigned MW  = 64;
   localparam logic [DW-1:0] HW = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_data;
   logic          imem_busy;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          inst_valid;
   logic [DW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic          inst_ready;
   logic          halt;
   logic          fault;

   logic [DW-1:0] tbmem [0:255];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // reference model: queue of {word, pc}
   logic [DW+AW-1:0] q [$];
   logic [AW-1:0]    mpc;
   bit               mhalt;
   bit               mfault;

   always #5 clk = ~clk;

   assign imem_data = tbmem[imem_addr[7:0]];

   instr_fetch #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .DEPTH     (DEP),
      .MEM_WORDS (MW),
      .RESET_PC  (16'h0000),
      .HALT_WORD (HW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .imem_busy      (imem_busy),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .halt           (halt),
      .fault          (fault)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit pop;
      pop = (q.size() != 0) && inst_ready;
      if (reset) begin
         q.delete();
         mpc    = '0;
         mhalt  = 0;
         mfault = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (redirect_valid) begin
            q.delete();
            mpc    = redirect_pc;
            mhalt  = 0;
            mfault = 0;
         end else if (!imem_busy && !mhalt && !mfault) begin
            if (int'(mpc) >= MW) mfault = 1;
            else if (q.size() < DEP) begin
               if (tbmem[mpc[7:0]] == HW) mhalt = 1;
               else begin
                  q.push_back({tbmem[mpc[7:0]], mpc});
                  mpc = mpc + 16'd1;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [DW+AW-1:0] h;
      h = (q.size() != 0) ? q[0] : '0;
      check("inst_valid", inst_valid, (q.size() != 0));
      check("inst",       inst,       h[DW+AW-1:AW]);
      check("inst_pc",    inst_pc,    h[AW-1:0]);
      check("imem_addr",  imem_addr,  mpc);
      check("halt",       halt,       mhalt);
      check("fault",      fault,      mfault);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic steps(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [AW-1:0] frozen;
      for (int i = 0; i < 256; i++) begin
         tbmem[i] = $urandom;
         if (tbmem[i] == HW) tbmem[i] = 32'h0;
      end
      reset = 1; imem_busy = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 1;
      q.delete(); mpc = '0; mhalt = 0; mfault = 0;
      #1;
      steps(2);
      check("reset_valid", inst_valid, 1'b0);
      check("reset_inst",  inst,       32'h0);

      // stream A,B,C,D with ready held high
      reset = 0;
      for (int unsigned k = 0; k < 4; k++) begin
         step();
         check("stream_inst", inst,    tbmem[k]);
         check("stream_pc",   inst_pc, k);
      end

      // backpressure: ready low for 5 cycles fills FIFO and freezes pc
      reset = 1; step(); reset = 0;
      inst_ready = 0;
      steps(5);
      check("bp_pc",   imem_addr, 16'd2);
      check("bp_inst", inst,      tbmem[0]);
      inst_ready = 1;
      for (int unsigned k = 1; k < 4; k++) begin
         step();
         check("bp_drain", inst, tbmem[k]);
      end

      // redirect flushes buffered words
      steps(2);
      redirect_valid = 1; redirect_pc = 16'h20;
      step();
      redirect_valid = 0;
      check("redir_empty", inst_valid, 1'b0);
      step();
      check("redir_pc", inst_pc, 16'h20);
      steps(3);

      // HALT word at address 2
      tbmem[2] = HW;
      reset = 1; step(); reset = 0;
      steps(6);
      check("halt_set",  halt,      1'b1);
      check("halt_pc",   imem_addr, 16'd2);
      redirect_valid = 1; redirect_pc = 16'h0;
      step();
      redirect_valid = 0;
      check("halt_clear", halt, 1'b0);
      steps(4);
      tbmem[2] = 32'h1234_5678;

      // out-of-range fault at the top of memory
      redirect_valid = 1; redirect_pc = 16'(MW - 3);
      step();
      redirect_valid = 0;
      steps(7);
      check("fault_set",  fault,     1'b1);
      check("fault_addr", imem_addr, 16'(MW));
      redirect_valid = 1; redirect_pc = 16'h0;
      step();
      redirect_valid = 0;
      check("fault_clear", fault, 1'b0);

      // loader hold-off mid-stream
      steps(3);
      frozen = imem_addr;
      imem_busy = 1;
      steps(3);
      check("busy_pc", imem_addr, frozen);
      imem_busy = 0;
      steps(3);

      // random traffic
      tbmem[40] = HW;
      for (int unsigned c = 0; c < 400; c++) begin
         inst_ready     = 1'($urandom_range(0, 1));
         imem_busy      = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 14) == 0);
         redirect_pc    = 16'($urandom_range(0, MW + 2));
         reset          = ($urandom_range(0, 59) == 0);
         step();
      end
      reset = 0; redirect_valid = 0; imem_busy = 0; inst_ready = 1;

      // reset mid-stream
      steps(3);
      reset = 1;
      step();
      check("mid_reset_valid", inst_valid, 1'b0);
      check("mid_reset_pc",    inst_pc,    16'h0);
      check("mid_reset_addr",  imem_addr,  16'h0);
      reset = 0;
      steps(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
